// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a five-stage in-order core.
// Produces ALU and branch-comparator forwarding selects, load-use and
// branch-operand stalls, and a memory-wait FSM that freezes the pipeline
// while data memory is busy and latches a terminal error on timeout.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rs_e,
  input  logic [4:0]       rt_e,
  input  logic [4:0]       writereg_e,
  input  logic             regwrite_e,
  input  logic             memtoreg_e,
  input  logic [4:0]       writereg_m,
  input  logic             regwrite_m,
  input  logic             memtoreg_m,
  input  logic [4:0]       writereg_w,
  input  logic             regwrite_w,
  input  logic             branch_d,
  input  logic             branch_taken_d,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             fwd_a_d,
  output logic             fwd_b_d,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // Wait counter only needs to reach MEM_TIMEOUT.
  localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic memstall;
  logic lwstall;
  logic brstall;

  // Nonzero-destination matches, shared by forwarding and stall detection.
  logic m_hit_rs_e, m_hit_rt_e, w_hit_rs_e, w_hit_rt_e;
  logic e_hit_rs_d, e_hit_rt_d, m_hit_rs_d, m_hit_rt_d;

  assign m_hit_rs_e = (writereg_m != 5'd0) && (writereg_m == rs_e);
  assign m_hit_rt_e = (writereg_m != 5'd0) && (writereg_m == rt_e);
  assign w_hit_rs_e = (writereg_w != 5'd0) && (writereg_w == rs_e);
  assign w_hit_rt_e = (writereg_w != 5'd0) && (writereg_w == rt_e);
  assign e_hit_rs_d = (writereg_e != 5'd0) && (writereg_e == rs_d);
  assign e_hit_rt_d = (writereg_e != 5'd0) && (writereg_e == rt_d);
  assign m_hit_rs_d = (writereg_m != 5'd0) && (writereg_m == rs_d);
  assign m_hit_rt_d = (writereg_m != 5'd0) && (writereg_m == rt_d);

  // ALU operand forwarding: the younger MEM result wins over WB.
  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (regwrite_m && m_hit_rs_e)      fwd_a_e = 2'b10;
    else if (regwrite_w && w_hit_rs_e) fwd_a_e = 2'b01;
    if (regwrite_m && m_hit_rt_e)      fwd_b_e = 2'b10;
    else if (regwrite_w && w_hit_rt_e) fwd_b_e = 2'b01;
  end

  assign fwd_a_d = regwrite_m && m_hit_rs_d;
  assign fwd_b_d = regwrite_m && m_hit_rt_d;

  // A load in EX cannot forward to ID in time; neither can any EX result or
  // a MEM load when the branch comparator needs it in ID.
  assign lwstall = memtoreg_e && (e_hit_rs_d || e_hit_rt_d);
  assign brstall = branch_d &&
                   ((regwrite_e && (e_hit_rs_d || e_hit_rt_d)) ||
                    (memtoreg_m && (m_hit_rs_d || m_hit_rt_d)));

  // Memory-wait FSM next state; memstall drops in the cycle mem_ready rises.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    memstall   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_req_m && !mem_ready) begin
          memstall   = 1'b1;
          state_d    = S_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else begin
          memstall = 1'b1;
          if (wait_cnt_q == WCW'(MEM_TIMEOUT)) state_d = S_ERR;
          else                                 wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      S_ERR: begin
        memstall = 1'b1;
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Stall/flush priority: memory freeze, then operand hazards, then branch flush.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (memstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (lwstall || brstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      flush_d = branch_taken_d;
    end
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = (state_q == S_ERR);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for the combinational
// forwarding/stall logic plus hand sequences for memory wait, timeout,
// counter saturation and asynchronous reset.
module tb_hazard_ctrl;

  localparam int CNT_W = 5;

  logic clk;
  logic reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w;
  logic branch_d, branch_taken_d, mem_req_m, mem_ready;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic fwd_a_d, fwd_b_d, mem_err;
  logic [CNT_W-1:0] stall_cnt;

  int passed = 0;
  int total  = 0;

  hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .writereg_m(writereg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
    .writereg_w(writereg_w), .regwrite_w(regwrite_w),
    .branch_d(branch_d), .branch_taken_d(branch_taken_d),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w, branch_d, taken}
  // ctl   = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  typedef struct packed {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
    logic [6:0] flags;
    logic [6:0] ctl;
    logic [1:0] fa, fb;
    logic       fad, fbd;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t v(input int a, b, c, d, e, m, w,
                             input int flags, ctl, fa, fb, fad, fbd);
    vec_t r;
    r.rs_d = 5'(a);  r.rt_d = 5'(b);  r.rs_e = 5'(c);  r.rt_e = 5'(d);
    r.wr_e = 5'(e);  r.wr_m = 5'(m);  r.wr_w = 5'(w);
    r.flags = 7'(flags);
    r.ctl   = 7'(ctl);
    r.fa = 2'(fa);  r.fb = 2'(fb);
    r.fad = 1'(fad); r.fbd = 1'(fbd);
    return r;
  endfunction

  function automatic logic [6:0] ctl_now();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    writereg_e = 0; writereg_m = 0; writereg_w = 0;
    regwrite_e = 0; memtoreg_e = 0; regwrite_m = 0; memtoreg_m = 0; regwrite_w = 0;
    branch_d = 0; branch_taken_d = 0; mem_req_m = 0; mem_ready = 1;
  endtask

  // Pulse reset between clock edges.
  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  initial begin
    int n;
    logic [12:0] act, exp;

    vecs[0]  = v(0,0,0,0,0,0,0, 'b0000000, 'b0000000, 0,0,0,0);
    vecs[1]  = v(0,0,5,0,0,5,5, 'b0010100, 'b0000000, 2,0,0,0);
    vecs[2]  = v(0,0,5,0,0,0,5, 'b0010100, 'b0000000, 1,0,0,0);
    vecs[3]  = v(0,0,9,7,0,9,7, 'b0010100, 'b0000000, 2,1,0,0);
    vecs[4]  = v(0,0,5,0,0,5,0, 'b0000000, 'b0000000, 0,0,0,0);
    vecs[5]  = v(0,0,0,0,0,0,0, 'b0000100, 'b0000000, 0,0,0,0);
    vecs[6]  = v(4,4,0,0,0,4,0, 'b0010000, 'b0000000, 0,0,1,1);
    vecs[7]  = v(0,8,0,0,8,0,0, 'b0100000, 'b1100010, 0,0,0,0);
    vecs[8]  = v(0,0,0,0,0,0,0, 'b0100000, 'b0000000, 0,0,0,0);
    vecs[9]  = v(1,2,0,0,0,0,0, 'b0000011, 'b0000100, 0,0,0,0);
    vecs[10] = v(3,0,0,0,3,0,0, 'b1000011, 'b1100010, 0,0,0,0);
    vecs[11] = v(0,6,0,0,0,6,0, 'b0001010, 'b1100010, 0,0,0,0);
    vecs[12] = v(0,6,0,0,0,6,0, 'b0001000, 'b0000000, 0,0,0,0);
    vecs[13] = v(3,0,0,0,3,0,0, 'b1000000, 'b0000000, 0,0,0,0);
    vecs[14] = v(0,8,0,0,8,0,0, 'b0100001, 'b1100010, 0,0,0,0);
    vecs[15] = v(6,0,0,0,0,6,0, 'b0010011, 'b0000100, 0,0,1,0);

    // Reset state and RUN evaluation while reset is held low.
    clear_inputs();
    reset = 1'b0;
    #2;
    check("reset_stall_cnt", 32'(stall_cnt), 0);
    check("reset_mem_err", 32'(mem_err), 0);
    check("reset_ctl", 32'(ctl_now()), 0);
    mem_req_m = 1; mem_ready = 0;
    #1 check("reset_run_memstall", 32'(ctl_now()), 32'b1111001);
    @(posedge clk); #1;
    check("reset_cnt_held", 32'(stall_cnt), 0);
    check("reset_no_err", 32'(mem_err), 0);
    @(negedge clk);
    clear_inputs();
    #1 reset = 1'b1;

    // Combinational vector table.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rs_d = vecs[i].rs_d; rt_d = vecs[i].rt_d;
      rs_e = vecs[i].rs_e; rt_e = vecs[i].rt_e;
      writereg_e = vecs[i].wr_e; writereg_m = vecs[i].wr_m; writereg_w = vecs[i].wr_w;
      {regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w,
       branch_d, branch_taken_d} = vecs[i].flags;
      #1;
      act = {ctl_now(), fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d};
      exp = {vecs[i].ctl, vecs[i].fa, vecs[i].fb, vecs[i].fad, vecs[i].fbd};
      $display("vec%0d: ctl=%b fa=%b fb=%b fad=%b fbd=%b", i,
               act[12:6], act[5:4], act[3:2], act[1], act[0]);
      check($sformatf("vec%0d", i), 32'(act), 32'(exp));
    end

    // Load-use stall lasts one cycle and bumps the counter once.
    clear_inputs();
    do_reset();
    @(negedge clk);
    memtoreg_e = 1; writereg_e = 8; rt_d = 8;
    #1 check("lw_ctl", 32'(ctl_now()), 32'b1100010);
    @(negedge clk);
    clear_inputs();
    #1;
    $display("loaduse: stall_cnt=%0d", stall_cnt);
    check("lw_cnt", 32'(stall_cnt), 1);
    check("lw_release", 32'(ctl_now()), 0);

    // Memory wait of three cycles, released with zero extra latency.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_req_m = 1; mem_ready = 0;
      #1 check($sformatf("memwait_c%0d", i), 32'(ctl_now()), 32'b1111001);
    end
    @(negedge clk);
    mem_ready = 1;
    #1 check("memwait_release", 32'(ctl_now()), 0);
    @(negedge clk);
    clear_inputs();
    #1;
    $display("memwait: stall_cnt=%0d", stall_cnt);
    check("memwait_cnt", 32'(stall_cnt), 3);

    // Timeout: one RUN stall cycle plus 15 WAIT cycles, then ERR.
    do_reset();
    @(negedge clk);
    mem_req_m = 1; mem_ready = 0;
    n = 0;
    while (!mem_err && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    $display("timeout: edges_to_err=%0d mem_err=%b", n, mem_err);
    check("timeout_edges", 32'(n), 16);
    check("timeout_cnt", 32'(stall_cnt), 16);
    @(negedge clk);
    mem_req_m = 0; mem_ready = 1;
    #1 check("err_stuck", 32'({mem_err, ctl_now()}), 32'b11111001);
    repeat (20) @(posedge clk);
    #1 check("cnt_saturate", 32'(stall_cnt), 31);

    // Asynchronous reset mid-cycle leaves ERR immediately.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    $display("async_reset: mem_err=%b ctl=%b cnt=%0d", mem_err, ctl_now(), stall_cnt);
    check("areset_err", 32'(mem_err), 0);
    check("areset_ctl", 32'(ctl_now()), 0);
    check("areset_cnt", 32'(stall_cnt), 0);
    #1 reset = 1'b1;
    @(negedge clk);
    #1 check("post_reset_run", 32'({mem_err, ctl_now()}), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
